// File: rtl/bcd_down_timer_pkg.sv
// Shared types, constants and helpers for the BCD down-counter.
package bcd_down_timer_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX  = 4'd9;
  localparam bcd_digit_t BCD_ZERO = 4'd0;

  // Non-BCD load values 10..15 saturate to 9.
  function automatic bcd_digit_t bcd_clamp(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of the down-counter: parallel load with clamp, borrow-gated decrement.
module bcd_down_digit
  import bcd_down_timer_pkg::*;
(
  input  logic       CK,
  input  logic       AR,
  input  logic       LD,
  input  logic [3:0] Din,
  input  logic       BI,
  input  logic       HOLD,
  output logic [3:0] Q,
  output logic       ZD
);

  bcd_digit_t q_q, q_d;

  // Next-state: load beats decrement; HOLD freezes the all-zero state when not wrapping.
  always_comb begin
    q_d = q_q;
    if (LD) begin
      q_d = bcd_clamp(Din);
    end else if (BI && !HOLD) begin
      q_d = (q_q == BCD_ZERO) ? BCD_MAX : bcd_digit_t'(q_q - 4'd1);
    end
  end

  // Digit register with asynchronous clear.
  always_ff @(posedge CK or posedge AR) begin
    if (AR) begin
      q_q <= BCD_ZERO;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q  = q_q;
  assign ZD = (q_q == BCD_ZERO);

endmodule

// File: rtl/bcd_down_timer.sv
// Cascadable presettable multi-digit BCD down-counter with zero, borrow and done outputs.
module bcd_down_timer
  import bcd_down_timer_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter bit          WRAP   = 1'b1
) (
  input  logic                CK,
  input  logic                AR,
  input  logic                LD,
  input  logic [4*DIGITS-1:0] D,
  input  logic                CE,
  output logic [4*DIGITS-1:0] Q,
  output logic                Z,
  output logic                BO,
  output logic                DONE
);

  localparam int NDig = int'(DIGITS);

  logic [NDig-1:0] zd;
  logic [NDig-1:0] bi;
  logic            hold;
  logic            upper_zero;
  logic            done_q, done_d;

  // Ripple-borrow chain: digit i steps only when every lower digit is zero.
  always_comb begin
    bi[0] = CE;
    for (int i = 1; i < NDig; i++) begin
      bi[i] = bi[i-1] & zd[i-1];
    end
  end

  assign Z    = &zd;
  assign BO   = CE & Z & ~LD;
  assign hold = ~WRAP & Z;

  for (genvar g = 0; g < NDig; g++) begin : g_digit
    bcd_down_digit u_digit (
      .CK   (CK),
      .AR   (AR),
      .LD   (LD),
      .Din  (D[4*g +: 4]),
      .BI   (bi[g]),
      .HOLD (hold),
      .Q    (Q[4*g +: 4]),
      .ZD   (zd[g])
    );
  end

  // A decrement lands on zero exactly when the count is 0..01.
  always_comb begin
    upper_zero = 1'b1;
    for (int i = 1; i < NDig; i++) begin
      upper_zero = upper_zero & zd[i];
    end
    done_d = CE & ~LD & upper_zero & (Q[3:0] == 4'd1);
  end

  // DONE pulse register.
  always_ff @(posedge CK or posedge AR) begin
    if (AR) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
    end
  end

  assign DONE = done_q;

endmodule

// File: tb/tb_bcd_down_timer.sv
// Directed self-checking bench for bcd_down_timer (wrapping, non-wrapping and cascaded).
module tb_bcd_down_timer;

  logic clk = 1'b0;
  logic ar;

  // Main DUT: 4 digits, wrapping.
  logic        ld, ce;
  logic [15:0] d, q;
  logic        z, bo, done;

  // Second DUT: 4 digits, non-wrapping.
  logic        ld2, ce2;
  logic [15:0] d2, q2;
  logic        z2, bo2, done2;

  // Cascade pair: 2 digits each, low BO drives high CE.
  logic       ldc, cec;
  logic [7:0] dlo, dhi, qlo, qhi;
  logic       zlo, bolo, donelo, zhi, bohi, donehi;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_down_timer #(.DIGITS(4), .WRAP(1'b1)) u_dut (
    .CK(clk), .AR(ar), .LD(ld), .D(d), .CE(ce), .Q(q), .Z(z), .BO(bo), .DONE(done)
  );

  bcd_down_timer #(.DIGITS(4), .WRAP(1'b0)) u_nowrap (
    .CK(clk), .AR(ar), .LD(ld2), .D(d2), .CE(ce2), .Q(q2), .Z(z2), .BO(bo2), .DONE(done2)
  );

  bcd_down_timer #(.DIGITS(2), .WRAP(1'b1)) u_lo (
    .CK(clk), .AR(ar), .LD(ldc), .D(dlo), .CE(cec), .Q(qlo), .Z(zlo), .BO(bolo), .DONE(donelo)
  );

  bcd_down_timer #(.DIGITS(2), .WRAP(1'b1)) u_hi (
    .CK(clk), .AR(ar), .LD(ldc), .D(dhi), .CE(bolo), .Q(qhi), .Z(zhi), .BO(bohi), .DONE(donehi)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] e;
    int v;

    ar = 1'b1; ld = 1'b0; ce = 1'b0; d = '0;
    ld2 = 1'b0; ce2 = 1'b0; d2 = '0;
    ldc = 1'b0; cec = 1'b0; dlo = '0; dhi = '0;
    tick();
    tick();
    chk("reset_q", q, 16'h0000);
    chk("reset_done", done, 1'b0);
    chk("reset_z", z, 1'b1);
    ar = 1'b0;

    // Load 0371, then asynchronous reset mid-cycle.
    ld = 1'b1; d = 16'h0371;
    tick();
    ld = 1'b0;
    chk("load_0371", q, 16'h0371);
    chk("load_0371_z", z, 1'b0);
    #2 ar = 1'b1;
    #1;
    chk("async_rst_q", q, 16'h0000);
    chk("async_rst_done", done, 1'b0);
    chk("async_rst_z", z, 1'b1);
    #1 ar = 1'b0;

    // Load 0012 and count down 12 edges.
    ld = 1'b1; d = 16'h0012;
    tick();
    ld = 1'b0; ce = 1'b1;
    chk("load_0012", q, 16'h0012);
    for (int k = 1; k <= 12; k++) begin
      tick();
      v = 12 - k;
      e = 16'((v / 10) * 16 + (v % 10));
      chk($sformatf("count_%0d", k), q, e);
      chk($sformatf("done_%0d", k), done, (v == 0) ? 1'b1 : 1'b0);
    end
    chk("zero_z", z, 1'b1);
    chk("wrap_bo", bo, 1'b1);
    // ce still high at zero: wraps to 9999, no DONE.
    tick();
    chk("wrap_q", q, 16'h9999);
    chk("wrap_done", done, 1'b0);
    chk("wrap_bo_after", bo, 1'b0);
    ce = 1'b0;

    // Borrow ripple.
    ld = 1'b1; d = 16'h1000;
    tick();
    ld = 1'b0; ce = 1'b1;
    chk("ripple_bo0", bo, 1'b0);
    tick();
    ce = 1'b0;
    chk("ripple_0999", q, 16'h0999);
    ld = 1'b1; d = 16'h0100;
    tick();
    ld = 1'b0; ce = 1'b1;
    tick();
    ce = 1'b0;
    chk("ripple_0099", q, 16'h0099);

    // Loading zero never raises DONE.
    ld = 1'b1; d = 16'h0000;
    tick();
    chk("load_zero_q", q, 16'h0000);
    chk("load_zero_done", done, 1'b0);

    // Clamp and LD over CE priority.
    ld = 1'b1; ce = 1'b1; d = 16'hA3F2;
    #1;
    chk("ld_masks_bo", bo, 1'b0);
    tick();
    chk("clamp_q", q, 16'h9392);
    chk("clamp_done", done, 1'b0);
    ld = 1'b0; ce = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("hold_q", q, 16'h9392);
    chk("hold_done", done, 1'b0);

    // Non-wrapping DUT.
    ld2 = 1'b1; d2 = 16'h0001;
    tick();
    ld2 = 1'b0; ce2 = 1'b1;
    tick();
    chk("nw_q_zero", q2, 16'h0000);
    chk("nw_done", done2, 1'b1);
    chk("nw_bo", bo2, 1'b1);
    tick();
    chk("nw_hold_q", q2, 16'h0000);
    chk("nw_hold_done", done2, 1'b0);
    chk("nw_hold_bo", bo2, 1'b1);
    ce2 = 1'b0;
    #1;
    chk("nw_bo_ce0", bo2, 1'b0);

    // Cascade: low 05, high 00.
    ldc = 1'b1; dlo = 8'h05; dhi = 8'h00;
    tick();
    ldc = 1'b0; cec = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    chk("casc_lo_00", qlo, 8'h00);
    chk("casc_hi_00", qhi, 8'h00);
    chk("casc_lo_done", donelo, 1'b1);
    chk("casc_bolo", bolo, 1'b1);
    chk("casc_bohi", bohi, 1'b1);
    tick();
    chk("casc_lo_99", qlo, 8'h99);
    chk("casc_hi_99", qhi, 8'h99);
    tick();
    chk("casc_lo_98", qlo, 8'h98);
    chk("casc_hi_hold", qhi, 8'h99);
    #2 ar = 1'b1;
    #1;
    chk("casc_rst_lo", qlo, 8'h00);
    chk("casc_rst_hi", qhi, 8'h00);
    #1 ar = 1'b0;
    cec = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
